itu656_decoder: RTL

//  Receive-side counterpart of the ADV7194 video encoder path: parses an ITU-656 (NTSC 525/60) 4:2:2 byte

---
 rtl/itu656_decoder_if.sv | 28 ++
 rtl/itu656_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/itu656_decoder_if.sv
// Byte-stream input and decoded timing/pixel outputs of itu656_decoder.
// The decoder takes the slave modport; the byte source / frame-buffer side takes master.
interface itu656_decoder_if #(
  parameter int vcbits   = 8,
  parameter int pairbits = 9
);
  logic                Enable;
  logic [9:0]          DIn;
  logic                OutValid;
  logic [31:0]         OutData;
  logic [vcbits:0]     OutLine;
  logic [pairbits-1:0] OutPair;
  logic                Field;
  logic                VBlank;
  logic                HBlank;
  logic                Locked;
  logic                SyncError;

  modport master (
    output Enable, DIn,
    input  OutValid, OutData, OutLine, OutPair, Field, VBlank, HBlank, Locked, SyncError
  );

  modport slave (
    input  Enable, DIn,
    output OutValid, OutData, OutLine, OutPair, Field, VBlank, HBlank, Locked, SyncError
  );
endinterface

// File: rtl/itu656_decoder.sv
// ITU-656 (525/60) 4:2:2 receiver: locks to EAV/SAV codes, tracks F/V/H, emits pixel pairs with line/pair address.
// Optional XY single-bit correction is enabled by defining ITU656_DECODER_ERRCORRECT_EN.
module itu656_decoder #(
  parameter int activesamples = 720,
  parameter int oddactive     = 244,
  parameter int vcbits        = 8,
  parameter int pairbits      = 9
) (
  input  logic             Clock,
  input  logic             Reset_B_,
  itu656_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    P3   = 2'd3
  } sync_state_t;

  localparam logic [pairbits-1:0] pairs_c    = pairbits'(activesamples / 2);
  localparam logic [vcbits-1:0]   line_max_c = {vcbits{1'b1}};

  function automatic logic [3:0] xy_parity(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  sync_state_t         state_r;
  sync_state_t         state_s;
  logic [7:0]          byte_s;
  logic [3:0]          par_s;
  logic [3:0]          syn_s;
  logic                f_s;
  logic                v_s;
  logic                h_s;
  logic                accept_s;
  logic                corrected_s;
  logic                code_s;
  logic                capture_s;
  logic                unused_s;

  logic [vcbits-1:0]   line_cnt_r;
  logic [pairbits-1:0] pair_cnt_r;
  logic [1:0]          byte_idx_r;
  logic [23:0]         shift_r;
  logic                prev_eav_r;
  logic                line_active_r;
  logic                seen_v_r;

  logic                out_valid_r;
  logic [31:0]         out_data_r;
  logic [vcbits:0]     out_line_r;
  logic [pairbits-1:0] out_pair_r;
  logic                field_r;
  logic                vblank_r;
  logic                hblank_r;
  logic                locked_r;
  logic                sync_error_r;

  assign byte_s   = bus.DIn[9:2];
  assign unused_s = (^bus.DIn[1:0]) ^ oddactive[0];

  // Sync-code state register.
  always_ff @(posedge Clock or negedge Reset_B_) begin
    if (!Reset_B_) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next sync state; FF and 00 never appear as active data, so a code can start anywhere.
  always_comb begin
    state_s = HUNT;
    if (!bus.Enable) begin
      state_s = HUNT;
    end else begin
      case (state_r)
        HUNT:    state_s = (byte_s == 8'hFF) ? P1 : HUNT;
        P1:      state_s = (byte_s == 8'h00) ? P2 : HUNT;
        P2:      state_s = (byte_s == 8'h00) ? P3 : HUNT;
        P3:      state_s = HUNT;
        default: state_s = HUNT;
      endcase
    end
  end

  // XY decode with protection-bit syndrome, plus active-capture qualifier.
  always_comb begin
    par_s       = xy_parity(byte_s[6], byte_s[5], byte_s[4]);
    syn_s       = byte_s[3:0] ^ par_s;
    f_s         = byte_s[6];
    v_s         = byte_s[5];
    h_s         = byte_s[4];
    accept_s    = 1'b0;
    corrected_s = 1'b0;
`ifdef ITU656_DECODER_ERRCORRECT_EN
    case (syn_s)
      4'b0000: accept_s = byte_s[7];
      4'b0111: begin
        f_s         = ~byte_s[6];
        accept_s    = byte_s[7];
        corrected_s = 1'b1;
      end
      4'b1011: begin
        v_s         = ~byte_s[5];
        accept_s    = byte_s[7];
        corrected_s = 1'b1;
      end
      4'b1101: begin
        h_s         = ~byte_s[4];
        accept_s    = byte_s[7];
        corrected_s = 1'b1;
      end
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        accept_s    = byte_s[7];
        corrected_s = 1'b1;
      end
      default: accept_s = 1'b0;
    endcase
`else
    if (syn_s == 4'b0000) begin
      accept_s = byte_s[7];
    end else begin
      accept_s = 1'b0;
    end
`endif
    code_s    = bus.Enable && (state_r == P3);
    capture_s = bus.Enable && (state_r == HUNT) && (byte_s != 8'hFF) &&
                locked_r && !hblank_r && !vblank_r;
  end

  // Timing tracking, line/pair counters and pixel-pair capture.
  always_ff @(posedge Clock or negedge Reset_B_) begin
    if (!Reset_B_) begin
      line_cnt_r    <= {vcbits{1'b0}};
      pair_cnt_r    <= {pairbits{1'b0}};
      byte_idx_r    <= 2'd0;
      shift_r       <= 24'd0;
      prev_eav_r    <= 1'b0;
      line_active_r <= 1'b0;
      seen_v_r      <= 1'b0;
      out_valid_r   <= 1'b0;
      out_data_r    <= 32'd0;
      out_line_r    <= {(vcbits + 1){1'b0}};
      out_pair_r    <= {pairbits{1'b0}};
      field_r       <= 1'b0;
      vblank_r      <= 1'b1;
      hblank_r      <= 1'b1;
      locked_r      <= 1'b0;
      sync_error_r  <= 1'b0;
    end else if (!bus.Enable) begin
      out_valid_r  <= 1'b0;
      locked_r     <= 1'b0;
      sync_error_r <= 1'b0;
      prev_eav_r   <= 1'b0;
    end else begin
      out_valid_r  <= 1'b0;
      sync_error_r <= 1'b0;
      if (code_s) begin
        if (accept_s) begin
          field_r      <= f_s;
          vblank_r     <= v_s;
          hblank_r     <= h_s;
          sync_error_r <= corrected_s;
          if (v_s) begin
            seen_v_r <= 1'b1;
          end
          if (h_s) begin
            // EAV: close the line; any partial pair is abandoned.
            if (line_active_r && (line_cnt_r != line_max_c)) begin
              line_cnt_r <= line_cnt_r + vcbits'(1);
            end
            line_active_r <= 1'b0;
            byte_idx_r    <= 2'd0;
            prev_eav_r    <= 1'b1;
          end else begin
            pair_cnt_r <= {pairbits{1'b0}};
            prev_eav_r <= 1'b0;
            if (prev_eav_r) begin
              locked_r <= 1'b1;
            end
            if (!v_s) begin
              byte_idx_r    <= 2'd0;
              line_active_r <= 1'b1;
              if (seen_v_r) begin
                line_cnt_r <= {vcbits{1'b0}};
                seen_v_r   <= 1'b0;
              end
            end
          end
        end else begin
          sync_error_r <= 1'b1;
          locked_r     <= 1'b0;
          prev_eav_r   <= 1'b0;
        end
      end else if (capture_s) begin
        shift_r    <= {shift_r[15:0], byte_s};
        byte_idx_r <= byte_idx_r + 2'd1;
        if (byte_idx_r == 2'd3) begin
          if (pair_cnt_r >= pairs_c) begin
            // Too many pairs before EAV: drop it and require a fresh EAV->SAV.
            sync_error_r <= 1'b1;
            locked_r     <= 1'b0;
          end else begin
            out_valid_r <= 1'b1;
            out_data_r  <= {shift_r, byte_s};
            out_line_r  <= {line_cnt_r, field_r};
            out_pair_r  <= pair_cnt_r;
            pair_cnt_r  <= pair_cnt_r + pairbits'(1);
          end
        end
      end
    end
  end

  assign bus.OutValid  = out_valid_r;
  assign bus.OutData   = out_data_r;
  assign bus.OutLine   = out_line_r;
  assign bus.OutPair   = out_pair_r;
  assign bus.Field     = field_r;
  assign bus.VBlank    = vblank_r;
  assign bus.HBlank    = hblank_r;
  assign bus.Locked    = locked_r;
  assign bus.SyncError = sync_error_r;

endmodule
